// File: rtl/reservation_station_if.sv
// Packet type shared by the dispatcher, the reservation station and its functional unit,
// plus the station's dispatch/CDB/issue bundle.
package rs_pkg;
  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;
  localparam int FU_W        = 2;
  localparam int FUNC_W      = 4;

  typedef struct packed {
    logic [FU_W-1:0]        fu;
    logic [FUNC_W-1:0]      func;
    logic [ROB_TAG_LEN-1:0] tag_dest;
    logic [ROB_TAG_LEN-1:0] tag_src1;
    logic [ROB_TAG_LEN-1:0] tag_src2;
    logic                   ready_src1;
    logic                   ready_src2;
    logic [XLEN-1:0]        value_src1;
    logic [XLEN-1:0]        value_src2;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        pc;
  } inst_rs_t;
endpackage

interface rs_if #(parameter int DEPTH = 4);
  import rs_pkg::*;

  logic                    load;
  inst_rs_t                inst_in;
  logic                    cdb_valid;
  logic [ROB_TAG_LEN-1:0]  cdb_tag;
  logic [XLEN-1:0]         cdb_value;
  logic                    fu_ready;
  logic                    is_full;
  logic                    issue_valid;
  inst_rs_t                issue_pack;
  logic [$clog2(DEPTH):0]  free_cnt;

  modport slave (
    input  load, inst_in, cdb_valid, cdb_tag, cdb_value, fu_ready,
    output is_full, issue_valid, issue_pack, free_cnt
  );

  modport master (
    output load, inst_in, cdb_valid, cdb_tag, cdb_value, fu_ready,
    input  is_full, issue_valid, issue_pack, free_cnt
  );
endinterface

// File: rtl/reservation_station.sv
// Per-FU reservation station: buffers renamed instructions, captures CDB operands, issues one
// ready instruction per cycle. Define RS_AGE_ORDER_EN for oldest-first select (default: lowest index).
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  input logic flush,
  rs_if.slave rs
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic     [DEPTH-1:0] valid_q, valid_d;
  inst_rs_t [DEPTH-1:0] ent_q,   ent_d;

  logic [CNT_W-1:0] free_cnt;
  logic             is_full;
  logic [DEPTH-1:0] cand;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] ins_idx;
  logic             issue_fire;
  logic             ins_ok;

`ifdef RS_AGE_ORDER_EN
  localparam int AGE_W = $clog2(DEPTH);
  logic [DEPTH-1:0][AGE_W-1:0] age_q, age_d;
  logic [AGE_W-1:0]            best_age;
`endif

  // Marks a source ready and captures the broadcast value when its tag is still pending.
  function automatic inst_rs_t wake(input inst_rs_t e, input logic v,
                                    input logic [ROB_TAG_LEN-1:0] tag,
                                    input logic [XLEN-1:0] value);
    inst_rs_t r;
    r = e;
    if (v && !e.ready_src1 && (e.tag_src1 == tag)) begin
      r.ready_src1 = 1'b1;
      r.value_src1 = value;
    end
    if (v && !e.ready_src2 && (e.tag_src2 == tag)) begin
      r.ready_src2 = 1'b1;
      r.value_src2 = value;
    end
    return r;
  endfunction

  // Occupancy, from registered state only so the dispatcher can use is_full combinationally.
  always_comb begin
    free_cnt = CNT_W'(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      free_cnt = free_cnt - CNT_W'(valid_q[i]);
    end
  end

  assign is_full = (free_cnt == '0);

  always_comb begin
    // NOTE: every signal gets a default before any conditional update so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = valid_q[i] & ent_q[i].ready_src1 & ent_q[i].ready_src2;
    end
`ifdef RS_AGE_ORDER_EN
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand[i] && (!sel_found || (age_q[i] > best_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
`endif
  end

  // Insert target is chosen from start-of-cycle validity, so a slot freed by issue is never reused
  // in the same cycle.
  always_comb begin
    ins_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) ins_idx = IDX_W'(i);
    end
  end

  assign issue_fire = sel_found & rs.fu_ready;
  assign ins_ok     = rs.load & ~is_full;

  assign rs.is_full     = is_full;
  assign rs.free_cnt    = free_cnt;
  assign rs.issue_valid = sel_found;
  assign rs.issue_pack  = sel_found ? ent_q[sel_idx] : '0;

  // NOTE: combinational next-state uses blocking '=' so later statements see earlier updates;
  // the state registers below use non-blocking '<=' only.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) ent_d[i] = wake(ent_q[i], rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
    end
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    if (ins_ok) begin
      valid_d[ins_idx] = 1'b1;
      ent_d[ins_idx]   = wake(rs.inst_in, rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
    end
  end

`ifdef RS_AGE_ORDER_EN
  // Age counts the younger entries still resident: inserts bump every resident entry, and an issue
  // pulls down the entries older than the one leaving, keeping ages distinct and below DEPTH.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (issue_fire && (age_q[i] > age_q[sel_idx])) age_d[i] = age_d[i] - 1'b1;
        if (ins_ok) age_d[i] = age_d[i] + 1'b1;
      end
    end
    if (ins_ok) age_d[ins_idx] = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
      // NOTE: entry payloads are cleared too, so no stale operands survive a squash.
      ent_q   <= '0;
`ifdef RS_AGE_ORDER_EN
      age_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
`ifdef RS_AGE_ORDER_EN
      age_q   <= age_d;
`endif
    end
  end

`ifndef SYNTHESIS
  load_when_full_a: assert property (@(posedge clk) disable iff (reset || flush)
                                     !(rs.load && is_full))
    else $error("reservation_station: load while full, packet dropped");
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected issues go into a scoreboard queue and a
// negedge monitor compares every issued packet; occupancy flags are checked inline.
module tb_reservation_station;
  import rs_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  rs_if #(.DEPTH(4)) rs ();

  reservation_station #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .rs    (rs.slave)
  );

  always #5 clk = ~clk;

  int       n_vec = 0;
  int       n_err = 0;
  inst_rs_t exp_q[$];

  function automatic inst_rs_t mk(input logic [4:0] dest,
                                  input logic [4:0] t1, input logic r1, input logic [31:0] v1,
                                  input logic [4:0] t2, input logic r2, input logic [31:0] v2);
    inst_rs_t p;
    p            = '0;
    p.fu         = 2'd1;
    p.func       = dest[3:0];
    p.tag_dest   = dest;
    p.tag_src1   = t1;
    p.ready_src1 = r1;
    p.value_src1 = v1;
    p.tag_src2   = t2;
    p.ready_src2 = r2;
    p.value_src2 = v2;
    p.imm        = {27'd0, dest};
    p.pc         = 32'h0000_1000 + {25'd0, dest, 2'b00};
    return p;
  endfunction

  function automatic inst_rs_t done(input inst_rs_t p, input logic [31:0] v1, input logic [31:0] v2);
    inst_rs_t r;
    r            = p;
    r.ready_src1 = 1'b1;
    r.value_src1 = v1;
    r.ready_src2 = 1'b1;
    r.value_src2 = v2;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] value);
    rs.cdb_valid = 1'b1;
    rs.cdb_tag   = tag;
    rs.cdb_value = value;
  endtask

  task automatic cdb_off();
    rs.cdb_valid = 1'b0;
    rs.cdb_tag   = '0;
    rs.cdb_value = '0;
  endtask

  task automatic load(input inst_rs_t p);
    rs.load    = 1'b1;
    rs.inst_in = p;
  endtask

  task automatic load_off();
    rs.load    = 1'b0;
    rs.inst_in = '0;
  endtask

  // Any cycle in which the FU accepts an instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && !flush && rs.issue_valid === 1'b1 && rs.fu_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got %h expected nothing", rs.issue_pack);
      end else begin
        inst_rs_t e;
        e = exp_q.pop_front();
        if (rs.issue_pack !== e) begin
          n_err++;
          $display("FAIL issue_pack: got %h expected %h", rs.issue_pack, e);
        end
      end
    end
  end

  inst_rs_t p0, p1, p2, p3, pe, px, py, pa, pb, pc;

  initial begin
    rs.fu_ready = 1'b0;
    load_off();
    cdb_off();

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_free_cnt", 32'(rs.free_cnt), 32'd4);
    check("rst_is_full", 32'(rs.is_full), 32'd0);
    check("rst_issue_valid", 32'(rs.issue_valid), 32'd0);
    check("rst_issue_pack_lo", rs.issue_pack[31:0], 32'd0);

    // Reset with two entries resident
    load(mk(5'd1, 5'd30, 1'b0, 32'd0, 5'd31, 1'b1, 32'h1));
    tick();
    load(mk(5'd2, 5'd30, 1'b0, 32'd0, 5'd31, 1'b1, 32'h2));
    tick();
    load_off();
    check("two_loaded_free", 32'(rs.free_cnt), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_issue_valid", 32'(rs.issue_valid), 32'd0);
    check("rst2_is_full", 32'(rs.is_full), 32'd0);
    check("rst2_free_cnt", 32'(rs.free_cnt), 32'd4);

    // Flush beats a concurrent load of a ready packet
    load(mk(5'd3, 5'd30, 1'b0, 32'd0, 5'd31, 1'b1, 32'h3));
    tick();
    check("one_loaded_free", 32'(rs.free_cnt), 32'd3);
    load(mk(5'd4, 5'd1, 1'b1, 32'h4, 5'd2, 1'b1, 32'h5));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    load_off();
    check("flush_free_cnt", 32'(rs.free_cnt), 32'd4);
    check("flush_issue_valid", 32'(rs.issue_valid), 32'd0);

    // Fill to full with src1 pending
    p0 = mk(5'd16, 5'd5, 1'b0, 32'd0, 5'd9, 1'b1, 32'h0900);
    p1 = mk(5'd17, 5'd6, 1'b0, 32'd0, 5'd9, 1'b1, 32'h0901);
    p2 = mk(5'd18, 5'd7, 1'b0, 32'd0, 5'd9, 1'b1, 32'h0902);
    p3 = mk(5'd19, 5'd8, 1'b0, 32'd0, 5'd9, 1'b1, 32'h0903);
    load(p0); tick();
    load(p1); tick();
    load(p2); tick();
    check("fill3_is_full", 32'(rs.is_full), 32'd0);
    check("fill3_free_cnt", 32'(rs.free_cnt), 32'd1);
    load(p3); tick();
    load_off();
    check("fill4_is_full", 32'(rs.is_full), 32'd1);
    check("fill4_free_cnt", 32'(rs.free_cnt), 32'd0);
    check("fill4_issue_valid", 32'(rs.issue_valid), 32'd0);

    // CDB wakeup: broadcast in N, issuable in N+1
    cdb(5'd5, 32'hDEAD_BEEF);
    tick();
    cdb_off();
    check("wake_issue_valid", 32'(rs.issue_valid), 32'd1);
    check("wake_value_src1", rs.issue_pack.value_src1, 32'hDEAD_BEEF);
    exp_q.push_back(done(p0, 32'hDEAD_BEEF, 32'h0900));
    rs.fu_ready = 1'b1;
    tick();
    rs.fu_ready = 1'b0;
    check("freed_is_full", 32'(rs.is_full), 32'd0);
    check("freed_free_cnt", 32'(rs.free_cnt), 32'd1);
    check("freed_issue_valid", 32'(rs.issue_valid), 32'd0);

    // Concurrent insert + issue with one free slot
    cdb(5'd7, 32'h0000_0077);
    tick();
    cdb_off();
    exp_q.push_back(done(p2, 32'h0000_0077, 32'h0902));
    pe = mk(5'd20, 5'd1, 1'b1, 32'hE1, 5'd2, 1'b1, 32'hE2);
    rs.fu_ready = 1'b1;
    load(pe);
    tick();
    rs.fu_ready = 1'b0;
    load_off();
    check("concur_free_cnt", 32'(rs.free_cnt), 32'd1);
    check("concur_is_full", 32'(rs.is_full), 32'd0);
    check("concur_issue_valid", 32'(rs.issue_valid), 32'd1);
    exp_q.push_back(pe);
    rs.fu_ready = 1'b1;
    tick();
    rs.fu_ready = 1'b0;
    check("concur_after_free", 32'(rs.free_cnt), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush2_free_cnt", 32'(rs.free_cnt), 32'd4);

    // Insert-cycle capture of both sources from one broadcast
    px = mk(5'd11, 5'd3, 1'b0, 32'd0, 5'd3, 1'b0, 32'd0);
    load(px);
    cdb(5'd3, 32'd7);
    tick();
    load_off();
    cdb_off();
    check("capture_issue_valid", 32'(rs.issue_valid), 32'd1);
    exp_q.push_back(done(px, 32'd7, 32'd7));
    rs.fu_ready = 1'b1;
    tick();
    rs.fu_ready = 1'b0;
    check("capture_free_cnt", 32'(rs.free_cnt), 32'd4);

    // A source that is already ready ignores a matching broadcast
    py = mk(5'd12, 5'd3, 1'b1, 32'h11, 5'd4, 1'b0, 32'd0);
    load(py);
    cdb(5'd3, 32'h99);
    tick();
    load_off();
    cdb_off();
    check("ready_ignore_valid", 32'(rs.issue_valid), 32'd0);
    cdb(5'd4, 32'h44);
    tick();
    cdb_off();
    check("ready_ignore_woken", 32'(rs.issue_valid), 32'd1);
    exp_q.push_back(done(py, 32'h11, 32'h44));
    rs.fu_ready = 1'b1;
    tick();
    rs.fu_ready = 1'b0;

    // Select order
    pa = mk(5'd21, 5'd20, 1'b0, 32'd0, 5'd9, 1'b1, 32'h9);
    pb = mk(5'd22, 5'd1, 1'b1, 32'hB1, 5'd2, 1'b1, 32'hB2);
    pc = mk(5'd23, 5'd1, 1'b1, 32'hC1, 5'd2, 1'b1, 32'hC2);
    load(pa); tick();
    load(pb); tick();
    load_off();
    cdb(5'd20, 32'h2020);
    tick();
    cdb_off();
    exp_q.push_back(done(pa, 32'h2020, 32'h9));
    rs.fu_ready = 1'b1;
    tick();
    rs.fu_ready = 1'b0;
    load(pc);
    tick();
    load_off();
    check("order_free_cnt", 32'(rs.free_cnt), 32'd2);
`ifdef RS_AGE_ORDER_EN
    exp_q.push_back(pb);
    exp_q.push_back(pc);
`else
    exp_q.push_back(pc);
    exp_q.push_back(pb);
`endif
    rs.fu_ready = 1'b1;
    tick();
    tick();
    rs.fu_ready = 1'b0;
    check("final_free_cnt", 32'(rs.free_cnt), 32'd4);
    check("final_issue_valid", 32'(rs.issue_valid), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
